// File: rtl/estimador_flow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : estimador_flow_pkg
// Brief    : Shared constants and width helpers for the loop-pipe flow control.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package estimador_flow_pkg;

    localparam int DONE_DEPTH_DEF = 2;
    localparam int INIT_II_DEF    = 1;
    localparam int CNT_W_DEF      = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Bits needed to hold 0..max_value, never narrower than one bit.
    function automatic int cnt_width(input int max_value);
        int w;
        w = clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/estimador_flow_updown_cnt.sv
`default_nettype none
// ============================================================================
// Module   : estimador_flow_updown_cnt
// Brief    : Saturating up/down counter; an increment arriving while full is
//            accepted only if a decrement frees a slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module estimador_flow_updown_cnt
    import estimador_flow_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int MAX   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_full,
    output logic             o_drop
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;
    logic             w_full;
    logic             w_dec;
    logic             w_inc;

    assign w_full = (r_count == c_MAX);
    assign w_dec  = i_dec & (r_count != '0);
    assign w_inc  = i_inc & (~w_full | w_dec);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_inc & ~w_dec) begin
            r_count <= r_count + 1'b1;
        end else if (w_dec & ~w_inc) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_drop  = i_inc & w_full & ~w_dec;

endmodule
`default_nettype wire

// File: rtl/estimador_func_flow_control_loop_pipe_cont.sv
`default_nettype none
// ============================================================================
// Module   : estimador_func_flow_control_loop_pipe_cont
// Brief    : Flow-control wrapper between the function FSM and a pipelined
//            loop body, with buffered completions and ap_continue handshake.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module estimador_func_flow_control_loop_pipe_cont
    import estimador_flow_pkg::*;
#(
    parameter int DONE_DEPTH = DONE_DEPTH_DEF,
    parameter int INIT_II    = INIT_II_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    input  logic             ap_continue,
    output logic             ap_ready,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_start_int,
    input  logic             ap_ready_int,
    input  logic             ap_done_int,
    output logic             ap_continue_int,
    output logic             ap_loop_init,
    input  logic             ap_loop_exit_ready,
    input  logic             ap_loop_exit_done,
    output logic [CNT_W-1:0] run_count,
    output logic             err_overflow
);

    localparam int c_PEND_W = cnt_width(DONE_DEPTH);
    localparam int c_INIT_W = cnt_width(INIT_II);
    localparam logic [c_INIT_W-1:0] c_INIT_RELOAD = c_INIT_W'(INIT_II);

    logic [c_PEND_W-1:0] w_pend;
    logic                w_pend_full;
    logic                w_drop;
    logic [c_INIT_W-1:0] r_init_cnt;
    logic [CNT_W-1:0]    r_run_count;
    logic                r_err_overflow;

    // Pending completions waiting for the outer FSM's ap_continue.
    estimador_flow_updown_cnt #(
        .WIDTH (c_PEND_W),
        .MAX   (DONE_DEPTH)
    ) u_pend_cnt (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .i_inc   (ap_done_int),
        .i_dec   (ap_done & ap_continue),
        .o_count (w_pend),
        .o_full  (w_pend_full),
        .o_drop  (w_drop)
    );

    // Exit reloads init before any same-cycle ready pulse can consume it.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_init_cnt <= c_INIT_RELOAD;
        end else if (ap_loop_exit_done) begin
            r_init_cnt <= c_INIT_RELOAD;
        end else if (ap_ready_int && (r_init_cnt != '0)) begin
            r_init_cnt <= r_init_cnt - 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_run_count    <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            if (ap_loop_exit_done) begin
                r_run_count <= r_run_count + 1'b1;
            end
            if (w_drop) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    assign ap_done         = (w_pend != '0);
    assign ap_continue_int = ~w_pend_full;
    assign ap_start_int    = ap_start & ap_continue_int;
    assign ap_ready        = ap_loop_exit_ready;
    assign ap_idle         = ~ap_start & (w_pend == '0);
    assign ap_loop_init    = (r_init_cnt != '0) & ap_start;
    assign run_count       = r_run_count;
    assign err_overflow    = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_estimador_func_flow_control_loop_pipe_cont.sv
`default_nettype none
// ============================================================================
// Module   : tb_estimador_func_flow_control_loop_pipe_cont
// Brief    : Directed plus randomized bench against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_estimador_func_flow_control_loop_pipe_cont;

    localparam int c_DEPTH = 2;
    localparam int c_II    = 3;
    localparam int c_CNTW  = 4;

    logic ap_clk = 1'b0;
    logic ap_rst, ap_start, ap_continue, ap_ready_int, ap_done_int;
    logic ap_loop_exit_ready, ap_loop_exit_done;
    logic ap_ready, ap_done, ap_idle, ap_start_int, ap_continue_int, ap_loop_init;
    logic [c_CNTW-1:0] run_count;
    logic err_overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of buffered completions plus plain counters.
    int pend_q[$];
    int m_init;
    int m_runs;
    bit m_err;

    always #5 ap_clk = ~ap_clk;

    estimador_func_flow_control_loop_pipe_cont #(
        .DONE_DEPTH (c_DEPTH),
        .INIT_II    (c_II),
        .CNT_W      (c_CNTW)
    ) dut (
        .ap_clk             (ap_clk),
        .ap_rst             (ap_rst),
        .ap_start           (ap_start),
        .ap_continue        (ap_continue),
        .ap_ready           (ap_ready),
        .ap_done            (ap_done),
        .ap_idle            (ap_idle),
        .ap_start_int       (ap_start_int),
        .ap_ready_int       (ap_ready_int),
        .ap_done_int        (ap_done_int),
        .ap_continue_int    (ap_continue_int),
        .ap_loop_init       (ap_loop_init),
        .ap_loop_exit_ready (ap_loop_exit_ready),
        .ap_loop_exit_done  (ap_loop_exit_done),
        .run_count          (run_count),
        .err_overflow       (err_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic st, input logic co, input logic ri, input logic di,
                          input logic xr, input logic xd, input logic rs);
        ap_start = st; ap_continue = co; ap_ready_int = ri; ap_done_int = di;
        ap_loop_exit_ready = xr; ap_loop_exit_done = xd; ap_rst = rs;
        #1;
    endtask

    task automatic model_reset();
        pend_q.delete();
        m_init = c_II;
        m_runs = 0;
        m_err  = 1'b0;
    endtask

    task automatic check_model();
        bit e_done;
        bit e_cont;
        e_done = (pend_q.size() != 0);
        e_cont = (pend_q.size() < c_DEPTH);
        check("ap_done", ap_done, e_done);
        check("ap_continue_int", ap_continue_int, e_cont);
        check("ap_start_int", ap_start_int, ap_start & e_cont);
        check("ap_ready", ap_ready, ap_loop_exit_ready);
        check("ap_idle", ap_idle, !ap_start && !e_done);
        check("ap_loop_init", ap_loop_init, (m_init > 0) && ap_start);
        check("run_count", run_count, m_runs % (1 << c_CNTW));
        check("err_overflow", err_overflow, m_err);
    endtask

    // Advance one clock edge, updating the model with the inputs seen at the edge.
    task automatic tick();
        @(posedge ap_clk);
        if (ap_rst) begin
            model_reset();
        end else begin
            if ((pend_q.size() != 0) && ap_continue) void'(pend_q.pop_front());
            if (ap_done_int) begin
                if (pend_q.size() < c_DEPTH) pend_q.push_back(m_runs);
                else m_err = 1'b1;
            end
            if (ap_loop_exit_done) m_init = c_II;
            else if (ap_ready_int && m_init > 0) m_init--;
            if (ap_loop_exit_done) m_runs = (m_runs + 1) % (1 << c_CNTW);
        end
        @(negedge ap_clk);
    endtask

    task automatic cycle(input logic st, input logic co, input logic ri, input logic di,
                         input logic xr, input logic xd, input logic rs);
        set_in(st, co, ri, di, xr, xd, rs);
        check_model();
        tick();
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        model_reset();

        // Reset state with a run requested
        set_in(1, 0, 0, 0, 0, 0, 0);
        check("rst_done", ap_done, 0);
        check("rst_cont_int", ap_continue_int, 1);
        check("rst_loop_init", ap_loop_init, 1);
        check("rst_start_int", ap_start_int, 1);
        check("rst_run_count", run_count, 0);
        check("rst_err", err_overflow, 0);
        check_model();
        tick();

        // Init held for three ready_int pulses, cleared on the fourth, re-armed on exit
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 1, 0, 0, 0, 0);
            if (i < 3) check("init_held", ap_loop_init, 1);
            else check("init_cleared", ap_loop_init, 0);
            check_model();
            tick();
        end
        cycle(1, 0, 1, 0, 1, 1, 0);
        set_in(1, 0, 0, 0, 0, 0, 0);
        check("init_rearm", ap_loop_init, 1);
        check("run_count_1", run_count, 1);
        tick();

        // Fill the pending buffer, then overflow it
        cycle(1, 0, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0);
        check("full_done", ap_done, 1);
        check("full_cont_int", ap_continue_int, 0);
        check("full_start_int", ap_start_int, 0);
        tick();
        cycle(1, 0, 0, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("ovf_err", err_overflow, 1);
        check("ovf_cont_int", ap_continue_int, 0);
        tick();
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("drain_done", ap_done, 0);
        check("drain_cont_int", ap_continue_int, 1);
        check("drain_idle", ap_idle, 1);
        tick();

        // Reset clears counters and the sticky error
        cycle(0, 0, 0, 0, 0, 0, 1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("rst2_err", err_overflow, 0);
        check("rst2_run_count", run_count, 0);
        tick();

        // Simultaneous completion and consume at pend=1 and at full
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("cancel_done", ap_done, 1);
        check("cancel_cont_int", ap_continue_int, 1);
        check("cancel_err", err_overflow, 0);
        tick();
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("full_cancel_err", err_overflow, 0);
        check("full_cancel_cont_int", ap_continue_int, 0);
        tick();

        // run_count wraps after 16 exits
        for (int i = 0; i < 17; i++) cycle(0, 1, 0, 0, 0, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("wrap_run_count", run_count, 1);
        tick();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 0, 1, 0);
        cycle(1, 0, 0, 1, 0, 1, 1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("midrst_run_count", run_count, 0);
        check("midrst_done", ap_done, 0);
        check("midrst_err", err_overflow, 0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 59) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
